// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : core_mem_arbiter
//  Purpose  : Shares one memory port between the instruction-fetch requester
//             and the load/store requester. One transaction is in flight at a
//             time; data wins ties unless fetch has been starved too long.
//  Revision : 1.0 - initial release
// ============================================================================
module core_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    // instruction-fetch requester
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    // load/store requester
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    // shared memory port
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    // debug status
    output logic                grant_d
);

    localparam int         C_STRB_W    = DATA_W / 8;
    localparam logic [3:0] C_MAX_BURST = 4'(MAX_D_BURST);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                take_i, take_d;
    logic                mem_req_q, mem_we_q, grant_d_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [C_STRB_W-1:0] mem_wstrb_q;
    logic [3:0]          starve_q, starve_d;

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and arbitration: data wins ties until fetch has waited
    // MAX_D_BURST consecutive data grants
    always_comb begin
        state_d = state_q;
        take_i  = 1'b0;
        take_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (d_req && !(if_req && (starve_q == C_MAX_BURST))) begin
                    take_d  = 1'b1;
                    state_d = S_BUSY_D;
                end else if (if_req) begin
                    take_i  = 1'b1;
                    state_d = S_BUSY_I;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Completion routing: ack and read data go only to the granted side,
    // and rdata reads as zero whenever that side's ack is low
    always_comb begin
        if_ack   = 1'b0;
        d_ack    = 1'b0;
        if_rdata = '0;
        d_rdata  = '0;
        if (mem_ack && (state_q == S_BUSY_I)) begin
            if_ack   = 1'b1;
            if_rdata = mem_rdata;
        end
        if (mem_ack && (state_q == S_BUSY_D)) begin
            d_ack   = 1'b1;
            d_rdata = mem_rdata;
        end
    end

    // Starvation counter next value: counts data grants that bypassed a
    // waiting fetch, saturating at the burst limit
    always_comb begin
        starve_d = starve_q;
        if (take_i) begin
            starve_d = 4'd0;
        end else if (take_d) begin
            if (!if_req) begin
                starve_d = 4'd0;
            end else if (starve_q != C_MAX_BURST) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Memory-port registers: latch the winner on the grant edge, hold while
    // busy, drop the request on the edge after mem_ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            grant_d_q   <= 1'b0;
        end else if (take_i) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            grant_d_q   <= 1'b0;
        end else if (take_d) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_wstrb_q <= d_wstrb;
            grant_d_q   <= 1'b1;
        end else if ((state_q != S_IDLE) && mem_ack) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign grant_d   = grant_d_q;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_mem_arbiter
//  Purpose  : Directed self-checking bench for core_mem_arbiter with a
//             wait-state memory model and per-requester scoreboards.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        grant_d;

    int   n_tests;
    int   n_fail;
    int   wait_cfg;
    int   wcnt;
    logic tie_ack;
    logic prev_req;
    int   busy_n;
    int   d_reraise;
    req_t cur;
    req_t qi[$];
    req_t qd[$];
    logic qg[$];

    core_mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_D_BURST (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .grant_d   (grant_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a pure function of address
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    // Memory responder: ack after wait_cfg wait states, or always when tied
    assign mem_ack   = tie_ack | (mem_req & (wcnt == wait_cfg));
    assign mem_rdata = mem_model(mem_addr);

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_i(input logic [31:0] a);
        req_t e;
        e.we = 1'b0; e.addr = a; e.wdata = '0; e.wstrb = '0;
        qi.push_back(e);
        if_addr = a;
        if_req  = 1'b1;
    endtask

    task automatic drive_d(input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ws);
        req_t e;
        e.we = we; e.addr = a; e.wdata = wd; e.wstrb = ws;
        qd.push_back(e);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_wstrb = ws;
        d_req   = 1'b1;
    endtask

    // One clock: sample 1 ns after the edge, check grants, bus stability,
    // acks against the scoreboards, then react like a well-behaved requester
    task automatic tick();
        logic exp_d;
        @(posedge clk);
        #1;
        if (mem_req && !prev_req) begin
            if (qg.size() == 0) begin
                chk("unexpected_grant", 72'(mem_req), 72'(0));
            end else begin
                exp_d = qg.pop_front();
                chk("grant_d", 72'(grant_d), 72'(exp_d));
                if (exp_d && qd.size() > 0)       cur = qd[0];
                else if (!exp_d && qi.size() > 0) cur = qi[0];
            end
            busy_n = 0;
        end
        if (mem_req) begin
            busy_n++;
            chk("mem_bus", 72'({mem_we, mem_addr, mem_wdata, mem_wstrb}),
                72'({cur.we, cur.addr, cur.wdata, cur.wstrb}));
        end
        prev_req = mem_req;
        if (!mem_req && mem_ack) begin
            chk("idle_ack", 72'({if_ack, d_ack}), 72'(0));
        end
        if (!if_ack) chk("if_rdata_zero", 72'(if_rdata), 72'(0));
        if (!d_ack)  chk("d_rdata_zero", 72'(d_rdata), 72'(0));
        if (if_ack) begin
            if (qi.size() == 0) begin
                chk("if_ack_unexpected", 72'(if_ack), 72'(0));
            end else begin
                cur = qi.pop_front();
                chk("if_rdata", 72'(if_rdata), 72'(mem_model(cur.addr)));
                chk("if_latency", 72'(busy_n), 72'(wait_cfg + 1));
                chk("if_ack_excl", 72'(d_ack), 72'(0));
            end
            if_req = 1'b0;
        end
        if (d_ack) begin
            if (qd.size() == 0) begin
                chk("d_ack_unexpected", 72'(d_ack), 72'(0));
            end else begin
                cur = qd.pop_front();
                chk("d_rdata", 72'(d_rdata), 72'(mem_model(cur.addr)));
                chk("d_latency", 72'(busy_n), 72'(wait_cfg + 1));
                chk("d_ack_excl", 72'(if_ack), 72'(0));
            end
            d_req = 1'b0;
            if (d_reraise > 0) begin
                d_reraise--;
                drive_d(1'b0, d_addr + 32'd4, 32'h0, 4'h0);
            end
        end
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        while ((qi.size() + qd.size() + qg.size()) != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        chk("drain_in_budget", 72'(qi.size() + qd.size() + qg.size()), 72'(0));
        tick();
    endtask

    initial begin
        int   n;
        int   last_ack;
        int   cyc;
        n_tests = 0; n_fail = 0;
        wait_cfg = 0; tie_ack = 1'b0; prev_req = 1'b0; busy_n = 0; d_reraise = 0;
        cur = '0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        rst_n = 1'b1;

        // Reset state, with a stray mem_ack present during reset
        #1 rst_n = 1'b0;
        tie_ack = 1'b1;
        #2;
        chk("rst_ctrl", 72'({mem_req, mem_we, if_ack, d_ack, grant_d}), 72'(0));
        chk("rst_mem_addr", 72'(mem_addr), 72'(0));
        chk("rst_mem_wdata", 72'({mem_wdata, mem_wstrb}), 72'(0));
        chk("rst_rdata", 72'({if_rdata, d_rdata}), 72'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        tie_ack = 1'b0;
        tick();

        // Single fetch, one wait state
        wait_cfg = 1;
        drive_i(32'h0000_0100);
        qg.push_back(1'b0);
        wait_done(20);

        // Store with three wait states; inputs scrambled and req dropped
        // after the grant must not disturb the latched transaction
        wait_cfg = 3;
        drive_d(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF);
        qg.push_back(1'b1);
        tick();
        d_wdata = 32'h0;
        d_addr  = 32'hFFFF_FFFC;
        d_wstrb = 4'h1;
        d_we    = 1'b0;
        d_req   = 1'b0;
        wait_done(20);

        // Simultaneous requests: data first, then fetch
        wait_cfg = 0;
        drive_d(1'b0, 32'h0000_3000, 32'h0, 4'h0);
        drive_i(32'h0000_0104);
        qg.push_back(1'b1);
        qg.push_back(1'b0);
        wait_done(20);

        // Starvation: exactly four data grants before fetch is forced; the
        // second round shows the counter started from zero again
        for (int r = 0; r < 2; r++) begin
            wait_cfg = 1;
            drive_i(32'h0000_0200 + 32'(r * 8));
            drive_d(1'b0, 32'h0000_4000 + 32'(r * 256), 32'h0, 4'h0);
            d_reraise = 4;
            qg.push_back(1'b1); qg.push_back(1'b1); qg.push_back(1'b1);
            qg.push_back(1'b1); qg.push_back(1'b0); qg.push_back(1'b1);
            wait_done(100);
        end

        // Reset mid-transaction: mem_req falls without a clock edge
        wait_cfg = 50;
        drive_d(1'b1, 32'h0000_5000, 32'hCAFE_F00D, 4'h3);
        qg.push_back(1'b1);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midop_rst_req", 72'({mem_req, mem_we, d_ack, if_ack}), 72'(0));
        qd.delete();
        d_req   = 1'b0;
        tie_ack = 1'b1;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_idle", 72'({mem_req, if_ack, d_ack}), 72'(0));
        end

        // Zero-wait memory with mem_ack tied high: ack in the first busy
        // cycle and exactly one idle cycle between back-to-back requests
        wait_cfg = 0;
        cyc      = 0;
        last_ack = 0;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                drive_i(32'h0000_0300 + 32'(k * 4));
                qg.push_back(1'b0);
            end else begin
                drive_d(k == 3, 32'h0000_6000 + 32'(k * 4), 32'h1111_0000 + 32'(k), 4'hC);
                qg.push_back(1'b1);
            end
            n = 0;
            do begin
                tick();
                cyc++;
                n++;
            end while (!(if_ack || d_ack) && n < 20);
            chk("zw_ack_seen", 72'(if_ack | d_ack), 72'(1));
            if (k > 0) chk("zw_turnaround", 72'(cyc - last_ack), 72'(2));
            last_ack = cyc;
        end
        tie_ack = 1'b0;
        wait_done(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
